// File: rtl/cpu_clk_pkg.sv
// Shared FSM state type and default timing constants for the CPU clock controller.
package cpu_clk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStepHi,
        StStepLo,
        StRunHi,
        StRunLo
    } clk_state_e;

    localparam int unsigned DefDebounceCycles = 500000;
    localparam int unsigned DefPulseHigh      = 4;
    localparam int unsigned DefPulseLow       = 4;
    localparam int unsigned DefRunDiv         = 25000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low key, accepts a level only after it has been stable long
// enough, and strobes press for one cycle on each accepted release-to-press transition.
module key_debounce
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;
    logic            press_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_raw};
            press_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CntMax) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    press_q <= ~sync_q[1];  // only the falling (pressed) edge is an event
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Single-step / free-running clock source for the multicycle CPU, with halt and edge count.
// Define CLKCTRL_BURST_EN to add sw_burst and BURST_LEN-pulse bursts per press.
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned PULSE_HIGH      = DefPulseHigh,
    parameter int unsigned PULSE_LOW       = DefPulseLow,
    parameter int unsigned RUN_DIV         = DefRunDiv,
`ifdef CLKCTRL_BURST_EN
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned BURST_LEN       = 8
`else
    parameter int unsigned CNT_W           = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_step,
    input  logic             sw_run,
    input  logic             halt_in,
`ifdef CLKCTRL_BURST_EN
    input  logic             sw_burst,
`endif
    output logic             cpu_clock,
    output logic             running,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned RunHigh  = RUN_DIV / 2;
    localparam int unsigned RunLow   = RUN_DIV - RunHigh;
    localparam int unsigned PhaseMax = max_u(max_u(PULSE_HIGH, PULSE_LOW), RunLow);
    localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

    localparam logic [PhaseW-1:0] StepHiLast = PhaseW'(PULSE_HIGH - 1);
    localparam logic [PhaseW-1:0] StepLoLast = PhaseW'(PULSE_LOW - 1);
    localparam logic [PhaseW-1:0] RunHiLast  = PhaseW'(RunHigh - 1);
    localparam logic [PhaseW-1:0] RunLoLast  = PhaseW'(RunLow - 1);

    clk_state_e        state_q;
    logic [PhaseW-1:0] phase_q;
    logic              cpu_clock_q;
    logic              busy_q;
    logic              running_q;
    logic [CNT_W-1:0]  step_count_q;
    logic [1:0]        run_sync_q;
    logic              press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock  (clock),
        .reset  (reset),
        .key_raw(key_step),
        .press  (press)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_sync_q <= 2'b00;
        end else begin
            run_sync_q <= {run_sync_q[0], sw_run};
        end
    end

`ifdef CLKCTRL_BURST_EN
    localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [1:0]        burst_sync_q;
    logic [BurstW-1:0] burst_q;  // pulses still owed after the current one

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_sync_q <= 2'b00;
        end else begin
            burst_sync_q <= {burst_sync_q[0], sw_burst};
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            cpu_clock_q  <= 1'b0;
            busy_q       <= 1'b0;
            running_q    <= 1'b0;
            step_count_q <= '0;
`ifdef CLKCTRL_BURST_EN
            burst_q      <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (run_sync_q[1] && !halt_in) begin
                        state_q      <= StRunHi;
                        cpu_clock_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        running_q    <= 1'b1;
                        step_count_q <= step_count_q + CNT_W'(1);
                    end else if (press) begin
                        state_q      <= StStepHi;
                        cpu_clock_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        step_count_q <= step_count_q + CNT_W'(1);
`ifdef CLKCTRL_BURST_EN
                        burst_q      <= burst_sync_q[1] ? BurstW'(BURST_LEN - 1) : '0;
`endif
                    end
                end
                StStepHi: begin
                    if (phase_q == StepHiLast) begin
                        state_q     <= StStepLo;
                        phase_q     <= '0;
                        cpu_clock_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + PhaseW'(1);
                    end
                end
                StStepLo: begin
                    if (phase_q == StepLoLast) begin
                        phase_q <= '0;
`ifdef CLKCTRL_BURST_EN
                        if (burst_q != '0 && !halt_in) begin
                            state_q      <= StStepHi;
                            cpu_clock_q  <= 1'b1;
                            step_count_q <= step_count_q + CNT_W'(1);
                            burst_q      <= burst_q - BurstW'(1);
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            burst_q <= '0;
                        end
`else
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        phase_q <= phase_q + PhaseW'(1);
                    end
                end
                StRunHi: begin
                    if (phase_q == RunHiLast) begin
                        state_q     <= StRunLo;
                        phase_q     <= '0;
                        cpu_clock_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + PhaseW'(1);
                    end
                end
                StRunLo: begin
                    if (phase_q == RunLoLast) begin
                        phase_q <= '0;
                        if (run_sync_q[1] && !halt_in) begin
                            state_q      <= StRunHi;
                            cpu_clock_q  <= 1'b1;
                            step_count_q <= step_count_q + CNT_W'(1);
                        end else begin
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                            running_q <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + PhaseW'(1);
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    phase_q     <= '0;
                    cpu_clock_q <= 1'b0;
                    busy_q      <= 1'b0;
                    running_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_clock  = cpu_clock_q;
    assign busy       = busy_q;
    assign running    = running_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: pulse-schedule model checked every cycle plus directed literals.
// A second 4-bit-counter instance exercises the step_count wrap.
module tb_cpu_clock_ctrl;

    localparam int DEB = 4;
    localparam int PH  = 2;
    localparam int PL  = 2;
    localparam int RD  = 6;
`ifdef CLKCTRL_BURST_EN
    localparam int BL  = 3;
`else
    localparam int BL  = 1;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        key_step = 1'b1;
    logic        sw_run   = 1'b0;
    logic        halt_in  = 1'b0;
    logic        sw_burst = 1'b0;
    logic        sw_run_w = 1'b0;
    logic        cpu_clock, running, busy;
    logic [15:0] step_count;
    logic        cpu_clock_w, running_w, busy_w;
    logic [3:0]  step_count_w;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_HIGH     (PH),
        .PULSE_LOW      (PL),
        .RUN_DIV        (RD),
`ifdef CLKCTRL_BURST_EN
        .CNT_W          (16),
        .BURST_LEN      (BL)
`else
        .CNT_W          (16)
`endif
    ) dut (
        .clock     (clk),
        .reset     (rst_n),
        .key_step  (key_step),
        .sw_run    (sw_run),
        .halt_in   (halt_in),
`ifdef CLKCTRL_BURST_EN
        .sw_burst  (sw_burst),
`endif
        .cpu_clock (cpu_clock),
        .running   (running),
        .busy      (busy),
        .step_count(step_count)
    );

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_HIGH     (PH),
        .PULSE_LOW      (PL),
        .RUN_DIV        (RD),
`ifdef CLKCTRL_BURST_EN
        .CNT_W          (4),
        .BURST_LEN      (BL)
`else
        .CNT_W          (4)
`endif
    ) dut_w (
        .clock     (clk),
        .reset     (rst_n),
        .key_step  (1'b1),
        .sw_run    (sw_run_w),
        .halt_in   (1'b0),
`ifdef CLKCTRL_BURST_EN
        .sw_burst  (1'b0),
`endif
        .cpu_clock (cpu_clock_w),
        .running   (running_w),
        .busy      (busy_w),
        .step_count(step_count_w)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a pulse is a period of high-then-low cycles; kind 0 idle, 1 step, 2 run.
    typedef struct packed {
        logic        k1, k2, deb, press, r1, r2, b1, b2;
        int          streak;
        int          kind;
        int          elapsed;
        int          burst_left;
        int unsigned count;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m     = '0;
        m.k1  = 1'b1;
        m.k2  = 1'b1;
        m.deb = 1'b1;
        return m;
    endfunction

    function automatic int period(input int kind);
        return (kind == 2) ? RD : PH + PL;
    endfunction

    function automatic int high_len(input int kind);
        return (kind == 2) ? RD / 2 : PH;
    endfunction

    function automatic model_t model_step(input model_t m, input logic key, input logic sw,
                                          input logic halt, input logic burst,
                                          input int unsigned modv);
        model_t n;
        bit     start;
        n     = m;
        start = 1'b0;
        n.k1 = key;   n.k2 = m.k1;
        n.r1 = sw;    n.r2 = m.r1;
        n.b1 = burst; n.b2 = m.b1;
        n.press = 1'b0;
        if (m.k2 != m.deb) begin
            n.streak = m.streak + 1;
            if (n.streak == DEB) begin
                n.deb    = m.k2;
                n.streak = 0;
                n.press  = !m.k2;
            end
        end else begin
            n.streak = 0;
        end
        if (m.kind != 0 && m.elapsed + 1 < period(m.kind)) begin
            n.elapsed = m.elapsed + 1;
        end else begin
            n.kind    = 0;
            n.elapsed = 0;
            if (m.kind == 1 && m.burst_left > 0 && !halt) begin
                n.kind = 1; n.burst_left = m.burst_left - 1; start = 1'b1;
            end else if (m.kind != 1 && m.r2 && !halt) begin
                n.kind = 2; start = 1'b1;
            end else if (m.kind == 0 && m.press) begin
                n.kind = 1; n.burst_left = m.b2 ? BL - 1 : 0; start = 1'b1;
            end
        end
        if (start) n.count = (m.count + 1) % modv;
        return n;
    endfunction

    function automatic logic model_clk(input model_t m);
        return (m.kind != 0) && (m.elapsed < high_len(m.kind));
    endfunction

    model_t m0, m1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 = model_reset();
            m1 = model_reset();
        end else begin
            m0 = model_step(m0, key_step, sw_run, halt_in, sw_burst, 65536);
            m1 = model_step(m1, 1'b1, sw_run_w, 1'b0, 1'b0, 16);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_clock", cpu_clock, model_clk(m0));
            check("busy", busy, m0.kind != 0);
            check("running", running, m0.kind == 2);
            check("step_count", step_count, m0.count);
            check("w_cpu_clock", cpu_clock_w, model_clk(m1));
            check("w_running", running_w, m1.kind == 2);
            check("w_step_count", step_count_w, m1.count);
        end
    end

    task automatic wait_rise(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_clock && n < 200);
        if (!cpu_clock) check("rise_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Starts on the first high cycle; ends on the first cycle after the low phase.
    task automatic measure_pulse(output int hi, output int lo);
        hi = 1;
        while (hi < 100) begin
            @(negedge clk);
            if (!cpu_clock) break;
            hi++;
        end
        lo = 1;
        while (lo < 100) begin
            @(negedge clk);
            if (cpu_clock || !busy) break;
            lo++;
        end
    endtask

    task automatic do_press(input string tag);
        int lat, hi, lo;
        key_step = 1'b0;
        wait_rise(lat);
        check({tag, "_latency"}, lat, 2 + DEB + 1);
        measure_pulse(hi, lo);
        check({tag, "_high"}, hi, PH);
        check({tag, "_low"}, lo, PL);
        key_step = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int lat, hi, lo, n;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_cpu_clock", cpu_clock, 0);
        check("rst_busy", busy, 0);
        check("rst_running", running, 0);
        check("rst_step_count", step_count, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_press("clean");
        check("clean_count", step_count, 1);

        for (int i = 0; i < 4; i++) begin
            key_step = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        check("bounce_no_pulse", step_count, 1);
        check("bounce_not_busy", busy, 0);
        do_press("bounce");
        check("bounce_count", step_count, 2);

        sw_run = 1'b1;
        wait_rise(lat);
        check("run_latency", lat, 3);
        measure_pulse(hi, lo);
        check("run_high", hi, 3);
        check("run_low", lo, 3);
        for (int i = 0; i < 51; i++) begin
            @(negedge clk);
            check("run_running", running, 1);
        end
        sw_run = 1'b0;
        check("run_count_range", (step_count >= 16'd11 && step_count <= 16'd13), 1);
        wait_idle();
        check("run_count", step_count, 12);

        sw_run = 1'b1;
        wait_rise(lat);
        check("halt_run_latency", lat, 3);
        @(negedge clk);
        halt_in = 1'b1;
        measure_pulse(hi, lo);
        check("halt_high_rest", hi, 2);
        check("halt_low", lo, 3);
        check("halt_running", running, 0);
        check("halt_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("halt_stays_low", cpu_clock, 0);
        check("halt_count", step_count, 13);
        do_press("halt_step");
        check("halt_step_count", step_count, 14);
        sw_run = 1'b0;
        repeat (4) @(negedge clk);
        halt_in = 1'b0;
        repeat (4) @(negedge clk);

        key_step = 1'b0;
        wait_rise(lat);
        check("pre_reset_clock", cpu_clock, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_clock", cpu_clock, 0);
        check("reset_mid_count", step_count, 0);
        key_step = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_press("post_reset");
        check("post_reset_count", step_count, 1);

`ifdef CLKCTRL_BURST_EN
        sw_burst = 1'b1;
        repeat (3) @(negedge clk);
        key_step = 1'b0;
        repeat (40) @(negedge clk);
        key_step = 1'b1;
        repeat (12) @(negedge clk);
        check("burst_count", step_count, 1 + BL);
        sw_burst = 1'b0;
        repeat (3) @(negedge clk);
`endif

        sw_run_w = 1'b1;
        n = 0;
        while (step_count_w != 4'd15 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wrap_reach_max", step_count_w, 15);
        n = 0;
        while (step_count_w == 4'd15 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wrap_to_zero", step_count_w, 0);
        check("wrap_on_rise", cpu_clock_w, 1);
        sw_run_w = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Upstream clock-stepping stage for the multicycle processor. Runs on the board clock and replaces the raw KEY[1] manual clock.
- Debounces the step key and emits clean single-step pulses on `cpu_clock`, or a free-running divided clock in run mode.
- Stops on a halt indication from the processor and keeps a count of issued `cpu_clock` rising edges for the HEX display.

Parameters:
- DEBOUNCE_CYCLES, 500000: board cycles the key must be stable before a level change is accepted (10 ms at 50 MHz).
- PULSE_HIGH, 4: board cycles `cpu_clock` stays high per step pulse; minimum 1.
- PULSE_LOW, 4: minimum board cycles `cpu_clock` stays low between pulses; minimum 1.
- RUN_DIV, 25000000: run-mode period in board cycles; high phase RUN_DIV/2 (floor), low phase RUN_DIV minus high; minimum 2.
- CNT_W, 16: width of step_count.

Ports:
- clock, in, 1: board clock.
- reset, in, 1: asynchronous, active-low reset (0 = reset). Connected directly to KEY[0].
- key_step, in, 1: raw step key, active-low, asynchronous to clock.
- sw_run, in, 1: 1 = run mode, 0 = single-step mode. Raw switch, asynchronous.
- halt_in, in, 1: processor halt request, level, synchronous to clock.
- cpu_clock, out, 1: clock to the processor, registered.
- running, out, 1: 1 while in run mode and issuing pulses.
- busy, out, 1: 1 while a pulse is in progress (high or low phase).
- step_count, out, CNT_W: number of cpu_clock rising edges since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - cpu_clock=0, running=0, busy=0, step_count=0.
  - State IDLE, debounce counter 0, debounced key = released.
  - Asserting reset mid-pulse forces cpu_clock low immediately.
- Synchronisation: key_step and sw_run each pass through a 2-flop synchroniser before any use.
- Debounce:
  - A counter increments while the synchronised key differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level updates.
  - A press event is a one-cycle strobe on the debounced high-to-low transition. Release generates no event.
- FSM states: IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO.
  - IDLE:
    - sw_run=1 and halt_in=0 -> RUN_HI.
    - Otherwise, a press event -> STEP_HI.
    - Press events arriving while not in IDLE are dropped; there is no queueing.
  - STEP_HI: cpu_clock=1 for PULSE_HIGH cycles -> STEP_LO.
  - STEP_LO: cpu_clock=0 for PULSE_LOW cycles -> IDLE.
  - RUN_HI: cpu_clock=1 for RUN_DIV/2 cycles -> RUN_LO.
  - RUN_LO: cpu_clock=0 for the remaining cycles. Then:
    - sw_run=1 and halt_in=0 -> RUN_HI.
    - Otherwise -> IDLE.
  - sw_run or halt_in changing mid-pulse never truncates the pulse; the current high and low phases always complete.
- Outputs per state:
  - cpu_clock is 1 exactly in STEP_HI and RUN_HI, and is registered (glitch-free).
  - busy = state is not IDLE.
  - running = state is RUN_HI or RUN_LO.
- step_count:
  - Increments on the board cycle where cpu_clock goes 0->1 (entry into STEP_HI or RUN_HI).
  - Wraps from 2^CNT_W-1 to 0.
- halt_in:
  - Sampled only in IDLE and at the end of RUN_LO.
  - Does not block single-step presses, so the processor can still be stepped after a halt.
- Latency:
  - Press to cpu_clock high: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1.
  - sw_run 0->1 in IDLE to cpu_clock high: 2 synchroniser cycles + 1.

Optional Feature:
- Macro CLKCTRL_BURST_EN.
- Defined:
  - Adds parameter BURST_LEN (default 8) and input sw_burst.
  - A press event with sw_burst=1 issues BURST_LEN consecutive step pulses (STEP_HI/STEP_LO pairs) before returning to IDLE.
  - A halt_in=1 seen at the end of any STEP_LO ends the burst early.
  - busy stays high for the whole burst.
- Undefined: sw_burst port absent; each press issues exactly one pulse.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - the FSM state enum (IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO);
  - the default constants for DEBOUNCE_CYCLES, PULSE_HIGH, PULSE_LOW and RUN_DIV.
- One sub-module, key_debounce: synchroniser, stable counter and press strobe, parameterised by DEBOUNCE_CYCLES. It is instantiated once for key_step.
- sw_run uses a plain 2-flop synchroniser.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, PULSE_HIGH=2, PULSE_LOW=2, RUN_DIV=6.
- Reset then a clean press (key_step 1->0 held 10 cycles) -> exactly one cpu_clock pulse, high for 2 cycles and low for ≥2; step_count=1.
- Press that bounces 0/1/0/1 at 2-cycle intervals, then a stable 0 -> no pulse during bouncing; exactly one pulse after 4 stable cycles.
- sw_run=1 for 60 board cycles -> period-6 clock with 3 high and 3 low; step_count=10±1; running=1 throughout.
- halt_in=1 asserted in the middle of RUN_HI -> the pulse completes (3 high, 3 low), then IDLE and running=0. A subsequent press still yields one step.
- reset pulled low during STEP_HI -> cpu_clock=0 in the same cycle; step_count=0. After release, a press yields step_count=1.
- Preload so step_count=16'hFFFF, then one step -> step_count=16'h0000. With CLKCTRL_BURST_EN, BURST_LEN=3, sw_burst=1 and one press -> 3 pulses and step_count advances by 3.
